// File: rtl/pass_pkg.sv
// Shared definitions for the password enrollment and password checking blocks.
// Holds the state encoding, slot geometry and the default terminator code.
package pass_pkg;

    localparam int SLOT_BITS = 3;
    localparam int ADDR_W    = 6;
    localparam int DIGIT_W   = 4;
    localparam int DATA_W    = 8;

    localparam int                PASS_MAX_DIGITS = 7;
    localparam logic [DATA_W-1:0] PASS_TERM_CODE  = 8'h1F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_COMMIT  = 3'd2,
        ST_TERM    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } pass_state_t;

    // A slot is eight consecutive words, so the word address is slot concatenated with offset.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_BITS-1:0] slot,
                                                    input logic [SLOT_BITS-1:0] offset);
        return {slot, offset};
    endfunction

endpackage

// File: rtl/pass_digit_buf.sv
// Small register file holding the digits of a password while it is being entered.
// One write port and one asynchronous index read port.
module pass_digit_buf
    import pass_pkg::*;
#(
    parameter int DEPTH = PASS_MAX_DIGITS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [SLOT_BITS-1:0] wr_idx,
    input  logic [DIGIT_W-1:0]   wr_data,
    input  logic [SLOT_BITS-1:0] rd_idx,
    output logic [DIGIT_W-1:0]   rd_data
);

    logic [DIGIT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < DEPTH)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The controller may point one past the last digit while it emits the terminator.
    assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/pass_enroll_controller.sv
// Collects keypad digits for one user slot and commits them to password memory,
// followed by a terminator word. Rejects empty or over-long entries without writing.
module pass_enroll_controller
    import pass_pkg::*;
#(
    parameter int                MAX_DIGITS = PASS_MAX_DIGITS,
    parameter logic [DATA_W-1:0] TERM_CODE  = PASS_TERM_CODE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enroll_start,
    input  logic [SLOT_BITS-1:0] address_user,
    input  logic [DIGIT_W-1:0]   pass_input,
    input  logic                 pass_load,
    input  logic                 pass_pound,
    output logic                 wr_en_pwd,
    output logic [ADDR_W-1:0]    address_pass,
    output logic [DATA_W-1:0]    data_pwd,
    output logic                 busy,
    output logic                 done,
    output logic                 wrong_len
);

    localparam logic [SLOT_BITS-1:0] MAX_CNT = SLOT_BITS'(MAX_DIGITS);

    pass_state_t          state;
    logic [SLOT_BITS-1:0] base_slot;
    logic [SLOT_BITS-1:0] count;
    logic [SLOT_BITS-1:0] idx;

    logic                 buf_wr;
    logic [SLOT_BITS-1:0] buf_rd_idx;
    logic [DIGIT_W-1:0]   buf_rd_data;

    // A pound in the same cycle as a load wins, so that digit never reaches the buffer.
    assign buf_wr     = (state == ST_COLLECT) && pass_load && !pass_pound &&
                        (count != MAX_CNT) && !rst;
    assign buf_rd_idx = (state == ST_COLLECT) ? '0 : idx;

    pass_digit_buf #(
        .DEPTH (MAX_DIGITS)
    ) u_digit_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_idx  (count),
        .wr_data (pass_input),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    // The first digit word is launched on the pound edge itself, so each state
    // registers the word that will be on the memory bus during the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            base_slot    <= '0;
            count        <= '0;
            idx          <= '0;
            wr_en_pwd    <= 1'b0;
            address_pass <= '0;
            data_pwd     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wrong_len    <= 1'b0;
        end else begin
            wr_en_pwd <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (enroll_start) begin
                        state     <= ST_COLLECT;
                        base_slot <= address_user;
                        count     <= '0;
                        idx       <= '0;
                        done      <= 1'b0;
                        wrong_len <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    if (pass_pound) begin
                        if (count == '0) begin
                            state     <= ST_ERROR;
                            wrong_len <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state        <= ST_COMMIT;
                            wr_en_pwd    <= 1'b1;
                            address_pass <= slot_addr(base_slot, '0);
                            data_pwd     <= {4'h0, buf_rd_data};
                            idx          <= SLOT_BITS'(1);
                        end
                    end else if (pass_load) begin
                        if (count == MAX_CNT) begin
                            state     <= ST_ERROR;
                            wrong_len <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                ST_COMMIT: begin
                    wr_en_pwd <= 1'b1;
                    if (idx == count) begin
                        state        <= ST_TERM;
                        address_pass <= slot_addr(base_slot, count);
                        data_pwd     <= TERM_CODE;
                    end else begin
                        address_pass <= slot_addr(base_slot, idx);
                        data_pwd     <= {4'h0, buf_rd_data};
                        idx          <= idx + 1'b1;
                    end
                end

                ST_TERM: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
